vrf_wr_arbiter: RTL
===================

# vrf_wr_arbiter

Round-robin arbiter that shares the single write port of the vector register file between `req_num_p` producers (vector lanes, load unit, reduction unit). It accepts at most one full-vector write per cycle through a valid/ready handshake, registers the winning beat, and drives the register file write port one cycle later. It also exports a pending-write bitmap so the issue logic can detect read-after-write hazards on the in-flight write.

## Interface
- `els_p`, 32: number of vector registers in the register file.
- `vlen_p`, 8: elements per vector.
- `vdw_p`, 32: bits per element.
- `req_num_p`, 4: number of write requesters, at least 2.
- `addr_width_lp`, `BSG_SAFE_CLOG2(els_p)`: register address width (localparam).
- `data_width_lp`, `vlen_p*vdw_p`: full-vector write width (localparam).

Ports:
- `clk_i` in 1: single clock. All state updates on its rising edge.
- `reset_i` in 1: asynchronous, active-low reset.
- `req_v_i` in `req_num_p`: per-requester write valid.
- `req_addr_i` in `req_num_p` x `addr_width_lp`: per-requester destination register.
- `req_data_i` in `req_num_p` x `data_width_lp`: per-requester write data.
- `req_ready_o` out `req_num_p`: one-hot grant; a beat transfers when `req_v_i[i] & req_ready_o[i]`.
- `freeze_i` in 1: blocks all grants this cycle; used for register file maintenance.
- `w_en_o` out 1: write enable to the register file.
- `w_addr_o` out `addr_width_lp`: write address.
- `w_data_o` out `data_width_lp`: write data.
- `pending_o` out `els_p`: bit `r` is set while a write to register `r` sits in the output stage.

## Operation
- State:
  - Round-robin pointer `ptr` with range 0..`req_num_p`-1.
  - Output stage holding the valid bit, address and data.
- Grant is combinational.
  - The block searches from `ptr` upward with wrap-around and grants the first `i` where `req_v_i[i]=1`.
  - `req_ready_o` is all-zero when `freeze_i=1` or no request is valid.
  - `req_ready_o[i]=1` implies `req_v_i[i]=1`. The grant vector is never more than one-hot.
- On a transfer to requester `k`:
  - The output stage loads `req_addr_i[k]` and `req_data_i[k]` and sets its valid bit.
  - `ptr` becomes (`k`+1) mod `req_num_p`.
- With no transfer, the valid bit clears and `ptr` holds its value.
- Outputs:
  - `w_en_o` is the output-stage valid bit.
  - `w_addr_o` and `w_data_o` come from the output-stage registers.
  - `pending_o` is the one-hot decode of `w_addr_o` gated by `w_en_o`. It is all-zero when `w_en_o=0`.
- Requester rule: after raising `req_v_i`, a requester keeps it high and keeps address and data stable until the transfer. The block does not check this rule.
- Fairness: a requester that holds valid high is granted within `req_num_p` unfrozen cycles.
- Same address from two requesters: the writes are serialized in grant order, and the later grant wins in the register file. The block does not merge them.
- The register file always accepts writes, so the output stage never back-pressures.

## Timing
- Reset values (asynchronous on the falling edge of `reset_i`, held while it is low):
  - `w_en_o`=0, `w_addr_o`=0, `w_data_o`=0, `pending_o`=0, `ptr`=0.
  - `req_ready_o`=0 for as long as reset is asserted.
- Latency: a transfer in cycle t gives `w_en_o`=1 in cycle t+1 for exactly one cycle. The register file commits at the end of t+1.
- Throughput: one write per cycle. Back-to-back transfers give `w_en_o` high continuously.
- `freeze_i` in cycle t:
  - No grant in t.
  - Does not affect a write already in the output stage, which drains in t.
- Reset mid-operation drops a write held in the output stage; it never reaches the register file.
- The first grant after reset release starts the search at requester 0.

## Configuration
- `VRF_WARB_STATS_EN` defined:
  - Adds output `grant_cnt_o`, sized `req_num_p` x 16.
  - Each entry is a saturating count of transfers for that requester. It holds at 16'hFFFF once saturated and resets to 0.
- `VRF_WARB_STATS_EN` undefined: the port and counters are absent. All other behaviour is identical.

## Test plan
- Reset:
  - Stimulus: assert `reset_i` low while `w_en_o`=1.
  - Required: `w_en_o`, `w_addr_o` and `pending_o` go to 0 immediately. No write appears after release.
- Single requester:
  - Stimulus: `req_v_i`=4'b0100, addr 5, data all-ones.
  - Required: `req_ready_o`=4'b0100 in the same cycle. Next cycle `w_en_o`=1, `w_addr_o`=5, `pending_o`=32'h20. Following cycle `w_en_o`=0.
- Full contention:
  - Stimulus: all four `req_v_i` held high for 8 cycles with `ptr`=0.
  - Required: grants 0,1,2,3,0,1,2,3. `w_en_o` high for 8 consecutive cycles starting one cycle later.
- Freeze:
  - Stimulus: requests 0 and 2 valid, `freeze_i`=1 for 3 cycles.
  - Required: `req_ready_o`=0 for those 3 cycles. Grant to 0 in the first unfrozen cycle, then 2. The in-flight write drains in the first frozen cycle.
- Same address:
  - Stimulus: requesters 1 and 3 both write addr 7 with data A and B.
  - Required: two consecutive `w_en_o` pulses to addr 7, with A then B.
- Statistics (`VRF_WARB_STATS_EN` defined):
  - Stimulus: 70000 transfers from requester 0.
  - Required: `grant_cnt_o[0]`=16'hFFFF. Other entries stay 0.

Source files
------------

// File: rtl/vrf_wr_arbiter.sv
// Round-robin arbiter for the vector register file write port.
// Optional per-requester grant counters under VRF_WARB_STATS_EN.
module vrf_wr_arbiter #(
   parameter int els_p     = 32,
   parameter int vlen_p    = 8,
   parameter int vdw_p     = 32,
   parameter int req_num_p = 4,
   localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1,
   localparam int data_width_lp = vlen_p * vdw_p
) (
   input  logic                                         clk_i,
   input  logic                                         reset_i,
   input  logic [req_num_p-1:0]                         req_v_i,
   input  logic [req_num_p-1:0][addr_width_lp-1:0]      req_addr_i,
   input  logic [req_num_p-1:0][data_width_lp-1:0]      req_data_i,
   output logic [req_num_p-1:0]                         req_ready_o,
   input  logic                                         freeze_i,
   output logic                                         w_en_o,
   output logic [addr_width_lp-1:0]                     w_addr_o,
   output logic [data_width_lp-1:0]                     w_data_o,
`ifdef VRF_WARB_STATS_EN
   output logic [req_num_p-1:0][15:0]                   grant_cnt_o,
`endif
   output logic [els_p-1:0]                             pending_o
);

   localparam int ptr_w_lp = (req_num_p > 1) ? $clog2(req_num_p) : 1;

   logic [ptr_w_lp-1:0]      ptr_q, ptr_d;
   logic                     v_q, v_d;
   logic [addr_width_lp-1:0] addr_q, addr_d;
   logic [data_width_lp-1:0] data_q, data_d;

   logic [req_num_p-1:0]     gnt;
   logic [ptr_w_lp-1:0]      win;
   logic                     xfer;
   int                       idx;

   // Walk offsets high to low so the nearest valid requester wins last.
   always_comb begin
      gnt = '0;
      win = '0;
      idx = 0;
      for (int off = req_num_p - 1; off >= 0; off--) begin
         idx = int'(ptr_q) + off;
         if (idx >= req_num_p) idx = idx - req_num_p;
         if (req_v_i[idx]) begin
            gnt      = '0;
            gnt[idx] = 1'b1;
            win      = ptr_w_lp'(idx);
         end
      end
   end

   assign req_ready_o = (freeze_i || !reset_i) ? '0 : gnt;
   assign xfer        = |req_ready_o;

   always_comb begin
      ptr_d  = ptr_q;
      v_d    = xfer;
      addr_d = addr_q;
      data_d = data_q;
      if (xfer) begin
         addr_d = req_addr_i[win];
         data_d = req_data_i[win];
         if (int'(win) == req_num_p - 1) ptr_d = '0;
         else ptr_d = win + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         ptr_q  <= '0;
         v_q    <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
      end else begin
         ptr_q  <= ptr_d;
         v_q    <= v_d;
         addr_q <= addr_d;
         data_q <= data_d;
      end
   end

   assign w_en_o    = v_q;
   assign w_addr_o  = addr_q;
   assign w_data_o  = data_q;
   assign pending_o = v_q ? (els_p'(1) << addr_q) : '0;

`ifdef VRF_WARB_STATS_EN
   logic [req_num_p-1:0][15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      for (int i = 0; i < req_num_p; i++) begin
         if (req_ready_o[i] && req_v_i[i] && cnt_q[i] != 16'hFFFF)
            cnt_d[i] = cnt_q[i] + 16'd1;
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end

   assign grant_cnt_o = cnt_q;
`endif

endmodule
